debug_trace_buffer: RTL and testbench

DEBUG_TRACE_BUFFER -- requirements
Module: debug_trace_buffer

---
 rtl/debug_trace_buffer.sv | 85 ++++++++
 tb/tb_debug_trace_buffer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/debug_trace_buffer.sv
// debug_trace_buffer: armable trace capture FIFO with PC trigger, length limit and drop counting
module debug_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int LEN_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     trace_valid,
  input  logic [31:0]              trace_pc,
  input  logic [31:0]              trace_instr,
  input  logic                     arm,
  input  logic                     trig_en,
  input  logic [31:0]              trig_pc,
  input  logic [LEN_W-1:0]         capture_len,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [31:0]              rd_pc,
  output logic [31:0]              rd_instr,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [LEN_W-1:0]         drop_count,
  output logic [1:0]               state
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      fill_q, fill_d;
  logic [LEN_W-1:0] acc_q, acc_d, drop_q, drop_d;
  logic [31:0]      mem_pc [DEPTH];
  logic [31:0]      mem_instr [DEPTH];
  logic             hit, beat, full, rd, wr, drop, last;
  assign hit        = trace_valid && trace_pc == trig_pc;
  // arm wins: the beat presented in the arm cycle belongs to no session
  assign beat       = !arm && trace_valid && (state_q == CAPTURE || (state_q == ARMED && hit));
  assign full       = fill_q == (AW+1)'(DEPTH);
  assign rd         = rd_valid && rd_ready;
  assign wr         = beat && (!full || rd);
  assign drop       = beat && full && !rd;
  assign last       = wr && capture_len != '0 && LEN_W'(acc_q + 1'b1) == capture_len;
  assign rd_valid   = fill_q != '0;
  assign rd_pc      = mem_pc[rd_ptr_q];
  assign rd_instr   = mem_instr[rd_ptr_q];
  assign fill       = fill_q;
  assign drop_count = drop_q;
  assign state      = state_q;
  assign fill_d     = fill_q + (AW+1)'(wr) - (AW+1)'(rd);
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    drop_d  = drop_q;
    if (arm) begin
      state_d = trig_en ? ARMED : CAPTURE;
      acc_d   = '0;
      drop_d  = '0;
    end else begin
      if (state_q == ARMED && hit) state_d = CAPTURE;
      if (last) state_d = DONE;
      acc_d  = wr ? LEN_W'(acc_q + 1'b1) : acc_q;
      drop_d = (drop && drop_q != '1) ? LEN_W'(drop_q + 1'b1) : drop_q;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      acc_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr ? AW'(wr_ptr_q + 1'b1) : wr_ptr_q;
      rd_ptr_q <= rd ? AW'(rd_ptr_q + 1'b1) : rd_ptr_q;
      fill_q   <= fill_d;
      acc_q    <= acc_d;
      drop_q   <= drop_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_pc[wr_ptr_q]    <= trace_pc;
      mem_instr[wr_ptr_q] <= trace_instr;
    end
  end
endmodule

// File: tb/tb_debug_trace_buffer.sv
// tb_debug_trace_buffer: directed stimulus with a queue scoreboard checked by a read monitor
module tb_debug_trace_buffer;
  localparam logic [31:0] K = 32'hDEAD_BEEF;
  logic        clk = 0, reset_n = 0;
  logic        trace_valid = 0, arm = 0, trig_en = 0, rd_ready = 0;
  logic [31:0] trace_pc = 0, trace_instr = 0, trig_pc = 0;
  logic [7:0]  capture_len = 0;
  logic        rd_valid;
  logic [31:0] rd_pc, rd_instr;
  logic [4:0]  fill;
  logic [7:0]  drop_count;
  logic [1:0]  state;
  int          checks = 0, failures = 0;
  logic [31:0] exp_q[$];

  debug_trace_buffer #(.DEPTH(16), .LEN_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .trace_valid(trace_valid), .trace_pc(trace_pc),
    .trace_instr(trace_instr), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .capture_len(capture_len), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc),
    .rd_instr(rd_instr), .fill(fill), .drop_count(drop_count), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      chk("rd_valid_vs_fill", 32'(rd_valid), 32'(fill != 0));
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) chk("unexpected_read", rd_pc, 32'hFFFF_FFFF);
        else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("rd_pc", rd_pc, e);
          chk("rd_instr", rd_instr, e ^ K);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic te, input logic [31:0] tp, input logic [7:0] len);
    arm = 1; trig_en = te; trig_pc = tp; capture_len = len;
    step();
    arm = 0;
  endtask

  task automatic beat(input logic [31:0] pc, input logic keep);
    trace_valid = 1; trace_pc = pc; trace_instr = pc ^ K;
    if (keep) exp_q.push_back(pc);
    step();
    trace_valid = 0;
  endtask

  task automatic drain();
    int n;
    rd_ready = 1;
    for (n = 0; n < 40 && fill != 0; n++) step();
    rd_ready = 0;
    chk("drain_timeout", 32'(n < 40), 32'd1);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    #12 reset_n = 1;
    step();
    chk("reset_state", 32'(state), 0);
    chk("reset_fill", 32'(fill), 0);
    chk("reset_rd_valid", 32'(rd_valid), 0);
    chk("reset_drop", 32'(drop_count), 0);
    beat(32'h40, 0);
    chk("idle_ignored_fill", 32'(fill), 0);
    // immediate capture, length 3
    do_arm(0, 0, 3);
    chk("imm_state_capture", 32'(state), 2);
    beat(32'h00, 1); beat(32'h04, 1);
    chk("imm_state_pre_done", 32'(state), 2);
    beat(32'h08, 1);
    chk("imm_state_done", 32'(state), 3);
    beat(32'h0C, 0); beat(32'h10, 0);
    chk("imm_fill", 32'(fill), 3);
    chk("imm_drop", 32'(drop_count), 0);
    drain();
    // PC trigger, unlimited
    do_arm(1, 32'h0C, 0);
    chk("trig_state_armed", 32'(state), 1);
    for (int i = 0; i < 6; i++) beat(32'(i * 4), i >= 3);
    chk("trig_state_capture", 32'(state), 2);
    chk("trig_fill", 32'(fill), 3);
    drain();
    // overflow
    do_arm(0, 0, 0);
    for (int i = 0; i < 20; i++) beat(32'h100 + 32'(i * 4), i < 16);
    chk("ovf_fill", 32'(fill), 16);
    chk("ovf_drop", 32'(drop_count), 4);
    rd_ready = 1;
    beat(32'h200, 1);
    rd_ready = 0;
    chk("ovf_rw_fill", 32'(fill), 16);
    chk("ovf_rw_drop", 32'(drop_count), 4);
    drain();
    // wrap with continuous reads
    do_arm(0, 0, 0);
    rd_ready = 1;
    for (int i = 0; i < 40; i++) begin
      beat(32'h1000 + 32'(i * 4), 1);
      chk("wrap_fill_le1", 32'(fill <= 1), 1);
    end
    drain();
    // DONE with drops, then re-arm
    do_arm(0, 0, 17);
    for (int i = 0; i < 18; i++) beat(32'h300 + 32'(i * 4), i < 16);
    chk("rearm_pre_state", 32'(state), 2);
    chk("rearm_pre_drop", 32'(drop_count), 2);
    rd_ready = 1;
    beat(32'h400, 1);
    rd_ready = 0;
    chk("rearm_done_state", 32'(state), 3);
    chk("rearm_done_fill", 32'(fill), 16);
    beat(32'h404, 0);
    chk("done_ignored_drop", 32'(drop_count), 2);
    chk("done_ignored_fill", 32'(fill), 16);
    do_arm(1, 32'hFFFF_0000, 0);
    chk("rearm_armed_state", 32'(state), 1);
    chk("rearm_drop_clear", 32'(drop_count), 0);
    chk("rearm_fill_kept", 32'(fill), 16);
    beat(32'h408, 0);
    chk("armed_nomatch_drop", 32'(drop_count), 0);
    do_arm(0, 0, 0);
    chk("rearm_capture_state", 32'(state), 2);
    drain();
    // asynchronous reset mid-capture
    do_arm(0, 0, 0);
    for (int i = 0; i < 5; i++) beat(32'h500 + 32'(i * 4), 0);
    chk("rst_pre_fill", 32'(fill), 5);
    #2 reset_n = 0;
    #1;
    chk("rst_async_state", 32'(state), 0);
    chk("rst_async_fill", 32'(fill), 0);
    chk("rst_async_rd_valid", 32'(rd_valid), 0);
    #1 reset_n = 1;
    step();
    chk("rst_after_fill", 32'(fill), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
